// File: rtl/sap_core.sv
// SAP-1 style accumulator core: five-step fetch/execute sequencer with on-chip RAM,
// a program-load port that holds the core, and registered output/flag status.
//
// state | meaning
// T0    | MAR <= PC
// T1    | IR <= RAM[MAR], PC <= PC+1
// T2    | decode: operand to MAR, LDI, jumps, OUT, HLT
// T3    | memory access: LDA/ADD/SUB read, STA write
// T4    | ALU writeback for ADD/SUB, flags update
module sap_core #(
    parameter int DATA_W = 8,
    localparam int ADDR_W = DATA_W - 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pr_mode,
    input  logic              pr_we,
    input  logic [ADDR_W-1:0] pr_address,
    input  logic [DATA_W-1:0] pr_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              halted,
    output logic              carry,
    output logic              zero,
    output logic [ADDR_W-1:0] pc
);

    typedef enum logic [2:0] {
        T0 = 3'd0,
        T1 = 3'd1,
        T2 = 3'd2,
        T3 = 3'd3,
        T4 = 3'd4
    } step_t;

    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    step_t             r_step;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_mar;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [DATA_W-1:0] r_ir;
    logic [DATA_W-1:0] r_out;
    logic              r_out_valid;
    logic              r_carry;
    logic              r_zero;
    logic              r_halted;
    logic [DATA_W-1:0] r_ram [0:2**ADDR_W-1];

    logic [3:0]        w_op;
    logic [ADDR_W-1:0] w_operand;
    logic [DATA_W-1:0] w_ram_rd;
    logic              w_is_sub;
    logic [DATA_W-1:0] w_b_op;
    logic [DATA_W:0]   w_sum;
    logic              w_ram_we;
    logic [ADDR_W-1:0] w_ram_addr;
    logic [DATA_W-1:0] w_ram_wdata;

    assign w_op      = r_ir[DATA_W-1:DATA_W-4];
    assign w_operand = r_ir[ADDR_W-1:0];
    assign w_ram_rd  = r_ram[r_mar];

    // SUB is A + ~B + 1, so carry out doubles as "no borrow"
    assign w_is_sub = (w_op == OP_SUB);
    assign w_b_op   = w_is_sub ? ~r_b : r_b;
    assign w_sum    = {1'b0, r_a} + {1'b0, w_b_op} + {{DATA_W{1'b0}}, w_is_sub};

    assign w_ram_we    = pr_mode ? pr_we
                                 : (!r_halted && (r_step == T3) && (w_op == OP_STA));
    assign w_ram_addr  = pr_mode ? pr_address : r_mar;
    assign w_ram_wdata = pr_mode ? pr_data : r_a;

    // RAM has no reset; a write is suppressed on any edge where rst is high
    always_ff @(posedge clk) begin
        if (!rst && w_ram_we) begin
            r_ram[w_ram_addr] <= w_ram_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_step      <= T0;
            r_pc        <= '0;
            r_mar       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_ir        <= '0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
            r_carry     <= 1'b0;
            r_zero      <= 1'b0;
            r_halted    <= 1'b0;
        end else if (pr_mode) begin
            r_step      <= T0;
            r_pc        <= '0;
            r_mar       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_ir        <= '0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
            r_carry     <= 1'b0;
            r_zero      <= 1'b0;
            r_halted    <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            if (!r_halted) begin
                case (r_step)
                    T0: begin
                        r_mar  <= r_pc;
                        r_step <= T1;
                    end
                    T1: begin
                        r_ir   <= w_ram_rd;
                        r_pc   <= r_pc + {{(ADDR_W-1){1'b0}}, 1'b1};
                        r_step <= T2;
                    end
                    T2: begin
                        case (w_op)
                            OP_LDA, OP_ADD, OP_SUB, OP_STA: r_mar <= w_operand;
                            OP_LDI: r_a <= {{(DATA_W-ADDR_W){1'b0}}, w_operand};
                            OP_JMP: r_pc <= w_operand;
                            OP_JC:  if (r_carry) r_pc <= w_operand;
                            OP_JZ:  if (r_zero)  r_pc <= w_operand;
                            OP_OUT: begin
                                r_out       <= r_a;
                                r_out_valid <= 1'b1;
                            end
                            OP_HLT: r_halted <= 1'b1;
                            default: ;
                        endcase
                        r_step <= T3;
                    end
                    T3: begin
                        case (w_op)
                            OP_LDA:         r_a <= w_ram_rd;
                            OP_ADD, OP_SUB: r_b <= w_ram_rd;
                            default: ;
                        endcase
                        r_step <= T4;
                    end
                    T4: begin
                        if ((w_op == OP_ADD) || (w_op == OP_SUB)) begin
                            r_carry <= w_sum[DATA_W];
                            r_a     <= w_sum[DATA_W-1:0];
                            r_zero  <= (w_sum[DATA_W-1:0] == '0);
                        end
                        r_step <= T0;
                    end
                    default: r_step <= T0;
                endcase
            end
        end
    end

    assign out_data  = r_out;
    assign out_valid = r_out_valid;
    assign halted    = r_halted;
    assign carry     = r_carry;
    assign zero      = r_zero;
    assign pc        = r_pc;

endmodule
